// File: rtl/mem_resp_regslice.sv
// Response-side register slice between L2 and L1: tracks one outstanding
// request, registers the L2 completion and measures how long it waited.
module mem_resp_regslice #(
  parameter int width     = 32,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 L2cache_read,
  input  logic                 L2cache_write,
  input  logic [31:0]          L2cache_address,
  input  logic [width-1:0]     L2cache_rdata,
  input  logic                 L2cache_resp,
  output logic [width-1:0]     L2cache_rdata_reg,
  output logic                 L2cache_resp_reg,
  output logic [31:0]          resp_address_reg,
  output logic                 req_block,
  output logic                 busy,
  output logic [cnt_width-1:0] last_latency,
  output logic                 err_spurious
);

  // state | meaning
  // IDLE  | no transaction outstanding, new request may be accepted
  // WAIT  | request forwarded, counting cycles until L2cache_resp
  // RESP  | one-cycle registered completion pulse to L1
  // DRAIN | stale L1 request still visible, inputs ignored
  typedef enum logic [1:0] {IDLE, WAIT, RESP, DRAIN} state_t;

  state_t               state, state_next;
  logic [cnt_width-1:0] cnt, cnt_inc;
  logic                 is_read;
  logic                 accept, complete, spurious;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (L2cache_read || L2cache_write) begin
          state_next = WAIT;
          accept     = 1'b1;
        end
      end
      WAIT: begin
        if (L2cache_resp) begin
          state_next = RESP;
          complete   = 1'b1;
        end
      end
      RESP:    state_next = DRAIN;
      DRAIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Saturating increment; the resp cycle itself counts toward the latency.
  assign cnt_inc  = (&cnt) ? cnt : cnt + cnt_width'(1);
  assign spurious = L2cache_resp && (state != WAIT);

  assign L2cache_resp_reg = (state == RESP);
  assign req_block        = (state == RESP) || (state == DRAIN);
  assign busy             = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      is_read           <= 1'b0;
      L2cache_rdata_reg <= '0;
      resp_address_reg  <= '0;
      last_latency      <= '0;
      err_spurious      <= 1'b0;
    end else begin
      state <= state_next;
      if (spurious) err_spurious <= 1'b1;
      if (accept) begin
        resp_address_reg <= L2cache_address;
        is_read          <= L2cache_read;
        cnt              <= '0;
      end
      if (state == WAIT) begin
        if (complete) begin
          last_latency <= cnt_inc;
          cnt          <= '0;
          if (is_read) L2cache_rdata_reg <= L2cache_rdata;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: doc/mem_resp_regslice.md
MEM_RESP_REGSLICE -- requirements
Module: mem_resp_regslice

Interface
REQ-001 SHALL have parameter width, default 32: L2 data width in bits.
REQ-002 SHALL have parameter cnt_width, default 16: latency counter width in bits.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port L2cache_read, input, 1: L1-side read request, unregistered.
REQ-006 SHALL have port L2cache_write, input, 1: L1-side write request, unregistered.
REQ-007 SHALL have port L2cache_address, input, 32: L1-side request address.
REQ-008 SHALL have port L2cache_rdata, input, width: read data from L2.
REQ-009 SHALL have port L2cache_resp, input, 1: L2 completion strobe.
REQ-010 SHALL have port L2cache_rdata_reg, output, width: registered read data to L1.
REQ-011 SHALL have port L2cache_resp_reg, output, 1: registered completion pulse to L1.
REQ-012 SHALL have port resp_address_reg, output, 32: address of the transaction being completed.
REQ-013 SHALL have port req_block, output, 1: suppresses request-slice forwarding while stale L1 request is visible.
REQ-014 SHALL have port busy, output, 1: a transaction is outstanding.
REQ-015 SHALL have port last_latency, output, cnt_width: WAIT cycles of the last completed transaction.
REQ-016 SHALL have port err_spurious, output, 1: sticky flag for an L2cache_resp with no outstanding transaction.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP and DRAIN.
REQ-018 In IDLE, if L2cache_read or L2cache_write is high, SHALL go to WAIT, latch the address into resp_address_reg and latch is_read = L2cache_read.
REQ-019 If read and write are both high in IDLE, SHALL treat the transaction as a read.
REQ-020 In WAIT, SHALL increment the latency counter each cycle, saturating at all-ones, and never wrap.
REQ-021 In WAIT, on L2cache_resp=1, SHALL go to RESP and capture L2cache_rdata into L2cache_rdata_reg only if is_read.
REQ-022 On a write completion, L2cache_rdata_reg SHALL keep its previous value.
REQ-023 On WAIT->RESP, last_latency SHALL be loaded with the counter value including the resp cycle; the counter then clears to 0.
REQ-024 L2cache_resp_reg SHALL be high for exactly the one RESP cycle, i.e. exactly one cycle after the L2cache_resp sample: a 1-cycle latency.
REQ-025 RESP SHALL go unconditionally to DRAIN, and DRAIN SHALL go unconditionally to IDLE.
REQ-026 In DRAIN, SHALL ignore L1 request inputs; a new request is accepted no earlier than the first IDLE cycle.
REQ-027 req_block SHALL be high in RESP and DRAIN and low otherwise.
REQ-028 busy SHALL be high in WAIT, RESP and DRAIN.
REQ-029 L2cache_rdata_reg and resp_address_reg SHALL stay stable outside capture events.
REQ-030 L2cache_resp=1 in IDLE, RESP or DRAIN SHALL set err_spurious, SHALL be otherwise ignored, and SHALL not change rdata.
REQ-031 If the IDLE case of REQ-030 coincides with a new request, SHALL still take the IDLE->WAIT transition.
REQ-032 err_spurious SHALL clear only on rst.
REQ-033 In WAIT, L2cache_read/L2cache_write deasserting SHALL not abort the transaction, which completes only on L2cache_resp.

Reset
REQ-034 When rst=1 at a rising edge, SHALL enter IDLE from any state, including mid-WAIT or RESP.
REQ-035 On reset, L2cache_rdata_reg, resp_address_reg, last_latency, the counter and is_read SHALL be 0.
REQ-036 On reset, L2cache_resp_reg, req_block, busy and err_spurious SHALL be 0.
REQ-037 rst SHALL take priority over every simultaneous input, including L2cache_resp.
REQ-038 An L2cache_resp in the cycle after reset release SHALL be treated as spurious.

Verification
REQ-039 Basic read: read, addr 0x0000_1040; resp after 3 WAIT cycles with rdata 0xDEADBEEF -> resp_reg pulses 1 cycle, rdata_reg=0xDEADBEEF, resp_address_reg=0x1040, last_latency=3, req_block high 2 cycles.
REQ-040 Write: write, addr 0x2000; resp after 5 cycles -> rdata_reg keeps 0xDEADBEEF, last_latency=5, resp_reg single pulse.
REQ-041 Spurious: L2cache_resp in IDLE with rdata 0x1234 -> err_spurious=1 sticky, rdata_reg unchanged, resp_reg stays 0.
REQ-042 Back-to-back: L1 holds read through RESP/DRAIN -> no second capture until IDLE; the next transaction enters WAIT on the first IDLE cycle.
REQ-043 Reset mid-WAIT: rst after 2 WAIT cycles, then resp -> state IDLE, all outputs 0, err_spurious=1 from the late resp.
REQ-044 Saturation: cnt_width=4, resp after 20 cycles -> last_latency=15, no wrap.
